// File: rtl/eqed_pkg.sv
// -----------------------------------------------------------------------------
// eqed_pkg
// Shared definitions for the E-QED signature checker slice.
//   - state_e      : checker FSM states (IDLE, RUN, DONE)
//   - *_DEF        : default signature width, lane count and window counter width
//   - MISR_SEED    : reset seed loaded into every MISR lane
// -----------------------------------------------------------------------------
package eqed_pkg;

    localparam int SIG_W_DEF   = 6;
    localparam int NUM_SIG_DEF = 3;
    localparam int WIN_W_DEF   = 10;

    localparam logic [5:0] MISR_SEED = 6'b000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/eqed_sig_cmp.sv
// -----------------------------------------------------------------------------
// eqed_sig_cmp
// Combinational per-lane equality of two packed signature buses.
// Ports:
//   a_i        [NUM_SIG*SIG_W] : live signatures, lane 0 in the LSBs
//   b_i        [NUM_SIG*SIG_W] : reference signatures, same packing
//   mismatch_o [NUM_SIG]       : bit i set when lane i differs
// -----------------------------------------------------------------------------
import eqed_pkg::*;

module eqed_sig_cmp #(
    parameter int SIG_W   = SIG_W_DEF,
    parameter int NUM_SIG = NUM_SIG_DEF
) (
    input  logic [NUM_SIG*SIG_W-1:0] a_i,
    input  logic [NUM_SIG*SIG_W-1:0] b_i,
    output logic [NUM_SIG-1:0]       mismatch_o
);

    // Lane-by-lane inequality
    always_comb begin
        mismatch_o = {NUM_SIG{1'b0}};
        for (int i = 0; i < NUM_SIG; i++) begin
            mismatch_o[i] = (a_i[i*SIG_W +: SIG_W] != b_i[i*SIG_W +: SIG_W]);
        end
    end

endmodule

// File: rtl/eqed_sig_checker.sv
// -----------------------------------------------------------------------------
// eqed_sig_checker
// Reads the E-QED input/output MISR signatures over a programmed capture
// window, checks them against the initial seed at offset 0 and against golden
// values at offset win_len, and reports a verdict plus the window offset of the
// first injected bit-flip.
// Optional feature: define EQED_FAIL_CNT_EN to add a saturating 8-bit count of
// failed verdicts on fail_cnt_o.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start_i          : one-cycle pulse starting a check (window offset 0)
//   win_len_i        : window length, sampled at start
//   sig_in_i         : live MISR values, lane 0 in the LSBs
//   init_sig_i       : expected signatures at offset 0
//   gold_sig_i       : expected signatures at offset win_len, sampled at start
//   inj_pulse_i      : bit-flip injected this cycle
//   busy_o, done_o   : check running / verdict valid
//   pass_o           : both window ends matched on every lane
//   init_fail_o      : offset-0 mismatch
//   cfg_err_o        : win_len was zero at start
//   mismatch_mask_o  : per-lane final mismatch
//   inj_seen_o       : an injection was observed in the window
//   inj_offset_o     : window offset of the first injection
//   fail_cnt_o       : failed verdict count (EQED_FAIL_CNT_EN only)
// -----------------------------------------------------------------------------
import eqed_pkg::*;

module eqed_sig_checker #(
    parameter int SIG_W   = SIG_W_DEF,
    parameter int NUM_SIG = NUM_SIG_DEF,
    parameter int WIN_W   = WIN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [WIN_W-1:0]         win_len_i,
    input  logic [NUM_SIG*SIG_W-1:0] sig_in_i,
    input  logic [NUM_SIG*SIG_W-1:0] init_sig_i,
    input  logic [NUM_SIG*SIG_W-1:0] gold_sig_i,
    input  logic                     inj_pulse_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     init_fail_o,
    output logic                     cfg_err_o,
    output logic [NUM_SIG-1:0]       mismatch_mask_o,
    output logic                     inj_seen_o,
    output logic [WIN_W-1:0]         inj_offset_o
`ifdef EQED_FAIL_CNT_EN
    ,
    output logic [7:0]               fail_cnt_o
`endif
);

    localparam int BUS_W = NUM_SIG * SIG_W;

    localparam logic [WIN_W-1:0] CNT_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] CNT_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    state_e             state_q,      state_d;
    logic [WIN_W-1:0]   cnt_q,        cnt_d;
    logic [WIN_W-1:0]   win_len_q,    win_len_d;
    logic [BUS_W-1:0]   gold_q,       gold_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    logic               init_fail_q,  init_fail_d;
    logic               cfg_err_q,    cfg_err_d;
    logic [NUM_SIG-1:0] mask_q,       mask_d;
    logic               inj_seen_q,   inj_seen_d;
    logic [WIN_W-1:0]   inj_offset_q, inj_offset_d;

    logic [BUS_W-1:0]   cmp_ref_s;
    logic [NUM_SIG-1:0] cmp_mask_s;

    // One shared comparator: seeds while idle/done (start cycle), latched gold while running
    assign cmp_ref_s = (state_q == RUN) ? gold_q : init_sig_i;

    eqed_sig_cmp #(
        .SIG_W   (SIG_W),
        .NUM_SIG (NUM_SIG)
    ) u_cmp (
        .a_i        (sig_in_i),
        .b_i        (cmp_ref_s),
        .mismatch_o (cmp_mask_s)
    );

    // Next-state and verdict logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_len_d    = win_len_q;
        gold_d       = gold_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        init_fail_d  = init_fail_q;
        cfg_err_d    = cfg_err_q;
        mask_d       = mask_q;
        inj_seen_d   = inj_seen_q;
        inj_offset_d = inj_offset_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    win_len_d    = win_len_i;
                    gold_d       = gold_sig_i;
                    cnt_d        = CNT_ONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    init_fail_d  = 1'b0;
                    cfg_err_d    = 1'b0;
                    mask_d       = {NUM_SIG{1'b0}};
                    inj_seen_d   = 1'b0;
                    inj_offset_d = CNT_ZERO;
                    if (win_len_i == CNT_ZERO) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cfg_err_d = 1'b1;
                    end else if (|cmp_mask_s) begin
                        // Offset-0 failure reports through init_fail; the lane mask stays clear
                        state_d     = DONE;
                        done_d      = 1'b1;
                        init_fail_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        busy_d     = 1'b1;
                        inj_seen_d = inj_pulse_i;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            RUN: begin
                // Only the first injection in the window is recorded
                if (inj_pulse_i && !inj_seen_q) begin
                    inj_seen_d   = 1'b1;
                    inj_offset_d = cnt_q;
                end else begin
                    inj_seen_d = inj_seen_q;
                end

                if (cnt_q == win_len_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mask_d  = cmp_mask_s;
                    pass_d  = ~(|cmp_mask_s);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                done_d       = 1'b0;
                pass_d       = 1'b0;
                init_fail_d  = 1'b0;
                cfg_err_d    = 1'b0;
                mask_d       = {NUM_SIG{1'b0}};
                inj_seen_d   = 1'b0;
                inj_offset_d = CNT_ZERO;
            end
        endcase
    end

    // State, window and verdict registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            win_len_q    <= CNT_ZERO;
            gold_q       <= {BUS_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            init_fail_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            mask_q       <= {NUM_SIG{1'b0}};
            inj_seen_q   <= 1'b0;
            inj_offset_q <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_len_q    <= win_len_d;
            gold_q       <= gold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            init_fail_q  <= init_fail_d;
            cfg_err_q    <= cfg_err_d;
            mask_q       <= mask_d;
            inj_seen_q   <= inj_seen_d;
            inj_offset_q <= inj_offset_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign init_fail_o     = init_fail_q;
    assign cfg_err_o       = cfg_err_q;
    assign mismatch_mask_o = mask_q;
    assign inj_seen_o      = inj_seen_q;
    assign inj_offset_o    = inj_offset_q;

`ifdef EQED_FAIL_CNT_EN
    logic       fail_evt_s;
    logic [7:0] fail_cnt_q;

    // A failed verdict is any entry into DONE without pass: from a start
    // (cfg_err/init_fail, including a restart out of DONE) or from the final compare
    assign fail_evt_s = (state_d == DONE) && ((state_q == RUN) || start_i) && !pass_d;

    // Saturating failed-verdict counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_q <= 8'd0;
        end else if (fail_evt_s && (fail_cnt_q != 8'hFF)) begin
            fail_cnt_q <= fail_cnt_q + 8'd1;
        end else begin
            fail_cnt_q <= fail_cnt_q;
        end
    end

    assign fail_cnt_o = fail_cnt_q;
`endif

endmodule

// File: tb/tb_eqed_sig_checker.sv
// -----------------------------------------------------------------------------
// tb_eqed_sig_checker
// Directed bench for eqed_sig_checker. Each check's expected verdict is
// derived from the stimulus and queued when the start pulse is driven; it is
// popped and compared when done rises. Inputs change 1 time unit after the
// rising edge and outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_eqed_sig_checker;
    import eqed_pkg::*;

    localparam int SIG_W   = 6;
    localparam int NUM_SIG = 3;
    localparam int WIN_W   = 10;
    localparam int BUS_W   = NUM_SIG * SIG_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIN_W-1:0]   win_len;
    logic [BUS_W-1:0]   sig_in;
    logic [BUS_W-1:0]   init_sig;
    logic [BUS_W-1:0]   gold_sig;
    logic               inj_pulse;
    logic               busy;
    logic               done;
    logic               pass;
    logic               init_fail;
    logic               cfg_err;
    logic [NUM_SIG-1:0] mismatch_mask;
    logic               inj_seen;
    logic [WIN_W-1:0]   inj_offset;
`ifdef EQED_FAIL_CNT_EN
    logic [7:0]         fail_cnt;
`endif

    eqed_sig_checker #(
        .SIG_W   (SIG_W),
        .NUM_SIG (NUM_SIG),
        .WIN_W   (WIN_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .win_len_i       (win_len),
        .sig_in_i        (sig_in),
        .init_sig_i      (init_sig),
        .gold_sig_i      (gold_sig),
        .inj_pulse_i     (inj_pulse),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .init_fail_o     (init_fail),
        .cfg_err_o       (cfg_err),
        .mismatch_mask_o (mismatch_mask),
        .inj_seen_o      (inj_seen),
        .inj_offset_o    (inj_offset)
`ifdef EQED_FAIL_CNT_EN
        ,
        .fail_cnt_o      (fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               pass;
        logic               init_fail;
        logic               cfg_err;
        logic [NUM_SIG-1:0] mask;
        logic               inj_seen;
        logic [WIN_W-1:0]   inj_offset;
        int                 latency;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one check. Offsets are counted in cycles from the start cycle (k=0).
    // inj_a < inj_b (or -1) give injection offsets; restart_at pulses start
    // again mid-window; abort_at asserts rst at that offset.
    task automatic run_check(input string name, input int wl,
                             input logic [BUS_W-1:0] s0, input logic [BUS_W-1:0] gold,
                             input logic [BUS_W-1:0] sfin,
                             input int inj_a, input int inj_b,
                             input int restart_at, input int abort_at);
        exp_t e;
        exp_t got;
        int   k;
        bit   seen_done;

        e.pass = 1'b0; e.init_fail = 1'b0; e.cfg_err = 1'b0;
        e.mask = '0;   e.inj_seen = 1'b0;  e.inj_offset = '0;
        if (wl == 0) begin
            e.cfg_err = 1'b1;
            e.latency = 1;
        end else if (s0 != init_sig) begin
            e.init_fail = 1'b1;
            e.latency   = 1;
        end else begin
            for (int i = 0; i < NUM_SIG; i++)
                e.mask[i] = (sfin[i*SIG_W +: SIG_W] != gold[i*SIG_W +: SIG_W]);
            e.pass    = (e.mask == '0);
            e.latency = wl + 1;
            if (inj_a >= 0 && inj_a <= wl) begin
                e.inj_seen = 1'b1; e.inj_offset = WIN_W'(inj_a);
            end else if (inj_b >= 0 && inj_b <= wl) begin
                e.inj_seen = 1'b1; e.inj_offset = WIN_W'(inj_b);
            end
        end
        if (abort_at < 0) sb_q.push_back(e);

        k = 0;
        seen_done = 1'b0;
        while (!seen_done && k < 1100) begin
            start     = (k == 0) || (k == restart_at);
            win_len   = (k == 0) ? WIN_W'(wl) : WIN_W'($urandom);
            gold_sig  = (k == 0) ? gold : BUS_W'($urandom);
            sig_in    = (k == 0) ? s0 : ((k == wl) ? sfin : BUS_W'($urandom));
            inj_pulse = (k == inj_a) || (k == inj_b);
            rst       = (k == abort_at);
            @(posedge clk); #1;
            k++;
            if (abort_at >= 0 && k == abort_at + 1) begin
                check({name, "_abort_busy"}, 32'(busy), 32'd0);
                check({name, "_abort_done"}, 32'(done), 32'd0);
                check({name, "_abort_inj"},  32'(inj_seen), 32'd0);
                rst = 1'b0; start = 1'b0; inj_pulse = 1'b0;
                exp_fail_cnt = 0;
`ifdef EQED_FAIL_CNT_EN
                check({name, "_abort_fcnt"}, 32'(fail_cnt), 32'd0);
`endif
                return;
            end
            if (done) seen_done = 1'b1;
            else if (k < e.latency) check({name, "_busy_run"}, 32'(busy), 32'd1);
        end
        start = 1'b0; inj_pulse = 1'b0; rst = 1'b0;

        check({name, "_done_seen"}, 32'(seen_done), 32'd1);
        check({name, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check({name, "_latency"},   32'(k), 32'(got.latency));
            check({name, "_busy_end"},  32'(busy), 32'd0);
            check({name, "_pass"},      32'(pass), 32'(got.pass));
            check({name, "_init_fail"}, 32'(init_fail), 32'(got.init_fail));
            check({name, "_cfg_err"},   32'(cfg_err), 32'(got.cfg_err));
            check({name, "_mask"},      32'(mismatch_mask), 32'(got.mask));
            check({name, "_inj_seen"},  32'(inj_seen), 32'(got.inj_seen));
            check({name, "_inj_off"},   32'(inj_offset), 32'(got.inj_offset));
            if (!got.pass && exp_fail_cnt < 255) exp_fail_cnt++;
`ifdef EQED_FAIL_CNT_EN
            check({name, "_fail_cnt"}, 32'(fail_cnt), 32'(exp_fail_cnt));
`endif
            // Verdict holds in DONE; stray injections are ignored
            inj_pulse = 1'b1;
            sig_in    = BUS_W'($urandom);
            repeat (3) @(posedge clk);
            #1;
            inj_pulse = 1'b0;
            check({name, "_hold_done"}, 32'(done), 32'd1);
            check({name, "_hold_pass"}, 32'(pass), 32'(got.pass));
            check({name, "_hold_mask"}, 32'(mismatch_mask), 32'(got.mask));
            check({name, "_hold_off"},  32'(inj_offset), 32'(got.inj_offset));
        end
    endtask

    logic [BUS_W-1:0] seeds;
    logic [BUS_W-1:0] gold_v;
    logic [BUS_W-1:0] bad_fin;
    logic [BUS_W-1:0] bad_init;

    initial begin
        seeds    = {3{MISR_SEED}};
        gold_v   = {6'b100010, 6'b110010, 6'b111010};
        bad_fin  = {6'b100010, 6'b110011, 6'b111010};
        bad_init = {6'b000011, 6'b000001, 6'b000001};
        init_sig = seeds;
        rst = 1'b1; start = 1'b0; win_len = '0; sig_in = '0;
        gold_sig = '0; inj_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_done",      32'(done), 32'd0);
        check("rst_pass",      32'(pass), 32'd0);
        check("rst_init_fail", 32'(init_fail), 32'd0);
        check("rst_cfg_err",   32'(cfg_err), 32'd0);
        check("rst_mask",      32'(mismatch_mask), 32'd0);
        check("rst_inj_seen",  32'(inj_seen), 32'd0);
        check("rst_inj_off",   32'(inj_offset), 32'd0);
`ifdef EQED_FAIL_CNT_EN
        check("rst_fail_cnt",  32'(fail_cnt), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_check("golden",   5, seeds, gold_v, gold_v,  -1, -1, -1, -1);
        run_check("final_mm", 5, seeds, gold_v, bad_fin, -1, -1, -1, -1);
        run_check("init_mm",  5, bad_init, gold_v, gold_v, -1, -1, -1, -1);
        run_check("inj",      5, seeds, gold_v, gold_v,   2,  4, -1, -1);
        run_check("cfg_err",  0, seeds, gold_v, gold_v,  -1, -1, -1, -1);
        run_check("restart",  5, seeds, gold_v, gold_v,  -1, -1,  3, -1);
        run_check("abort",    5, seeds, gold_v, gold_v,   1, -1, -1,  3);
        run_check("post_rst", 5, seeds, gold_v, gold_v,  -1, -1, -1, -1);
        run_check("inj_at0",  1, seeds, gold_v, ~gold_v,  0,  1, -1, -1);
        run_check("long_win", 40, seeds, bad_fin, bad_fin, 40, -1, -1, -1);
        run_check("inj_init", 4, bad_init, gold_v, gold_v, 0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
